// File: rtl/tok_src_pkg.sv
// Shared types and LFSR helper for the tagged token source.
package tok_src_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } state_t;

    localparam int unsigned LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tagged_token_source_if.sv
// Tagged-FIFO write bus: producer drives write/dataout, consumer drives per-flux full.
interface tagged_token_source_if #(
    parameter int unsigned FLUX  = 2,
    parameter int unsigned WIDTH = 9
);
    logic             write;
    logic [WIDTH-1:0] dataout;
    logic [FLUX-1:0]  full;

    modport master (output write, output dataout, input full);
    modport slave  (input write, input dataout, output full);
endinterface

// File: rtl/tok_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step enable.
module tok_lfsr
    import tok_src_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else if (load) begin
            state <= seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/tagged_token_source.sv
// Emits NUM_TOKENS {tag, lfsr data} tokens with round-robin tags under per-flux backpressure.
// Optional macro TOKSRC_RANDOM_GAP_EN inserts a one-cycle GAP after accepts whose stepped LFSR MSB is 1.
module tagged_token_source
    import tok_src_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = $clog2(FLUX),
    parameter int unsigned WIDTH      = DATA_WIDTH + TAG_WIDTH,
    parameter int unsigned NUM_TOKENS = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    tagged_token_source_if.master             out_port,
    output logic                              done,
    output logic [$clog2(NUM_TOKENS+1)-1:0]   tokens_sent
);

    localparam int unsigned CNT_W = $clog2(NUM_TOKENS + 1);

    state_t               state_q;
    state_t               state_d;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [TAG_WIDTH-1:0] tag_next;
    logic [CNT_W-1:0]     cnt_q;
    logic [LFSR_W-1:0]    lfsr_q;
    logic                 load;
    logic                 accept;
    logic                 last;
    logic                 unused_lfsr;

    assign load     = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept   = (state_q == RUN) && !out_port.full[tag_q];
    assign last     = accept && (cnt_q == CNT_W'(NUM_TOKENS - 1));
    assign tag_next = (tag_q == TAG_WIDTH'(FLUX - 1)) ? '0 : tag_q + TAG_WIDTH'(1);

    // Upper LFSR bits only feed the sequence itself when DATA_WIDTH < 16.
    assign unused_lfsr = ^lfsr_q;

`ifdef TOKSRC_RANDOM_GAP_EN
    logic [LFSR_W-1:0] lfsr_step;
    logic              gap_hit;
    logic              unused_step;

    assign lfsr_step   = lfsr_next(lfsr_q);
    assign gap_hit     = lfsr_step[LFSR_W-1];
    assign unused_step = ^lfsr_step[LFSR_W-2:0];
`endif

    tok_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (accept),
        .seed (SEED),
        .state(lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                // Last accept wins over any gap request.
                if (last) begin
                    state_d = DONE;
`ifdef TOKSRC_RANDOM_GAP_EN
                end else if (accept && gap_hit) begin
                    state_d = GAP;
`endif
                end
            end
`ifdef TOKSRC_RANDOM_GAP_EN
            GAP: state_d = RUN;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_port.write   = accept;
        out_port.dataout = '0;
        if (accept) begin
            out_port.dataout = {tag_q, lfsr_q[DATA_WIDTH-1:0]};
        end
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            tag_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            tag_q <= tag_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tokens_sent = cnt_q;

endmodule
